// File: rtl/dmem_subword_if.sv
// Request/response bus between the MEM stage (master) and the sub-word data memory (slave).
interface dmem_subword_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] address;
  logic [31:0] writedata;
  logic        rsp_valid;
  logic [31:0] readdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, address, writedata,
    input  req_ready, rsp_valid, readdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, address, writedata,
    output req_ready, rsp_valid, readdata, rsp_err
  );
endinterface

// File: rtl/dmem_subword_ctrl.sv
// Clocked MIPS data memory: byte/half/word loads and stores, programmable wait states.
// Optional alignment faulting is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_subword_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  dmem_subword_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_next;
  logic [2:0]       r_cnt;
  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      r_word;
  logic             r_write, r_uns, r_err;
  logic [1:0]       r_size, r_lane;

  logic             w_accept;
  logic             w_fault;
  logic [1:0]       w_size, w_lane;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [AW-1:0]    w_idx;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ext;

  assign w_idx    = bus.address[AW+1:2];
  assign w_accept = bus.req_valid && (r_state == S_IDLE);

  // Request decode: effective size, lane offset and fault status at accept time.
  always_comb begin
    w_fault = 1'b0;
    w_size  = bus.req_size;
    w_lane  = bus.address[1:0];
`ifdef DMEM_ALIGN_CHECK_EN
    case (bus.req_size)
      2'b01:   w_fault = bus.address[0];
      2'b10:   w_fault = |bus.address[1:0];
      2'b11:   w_fault = 1'b1;
      default: w_fault = 1'b0;
    endcase
`else
    if (bus.req_size == 2'b11) w_size = 2'b10;
    case (w_size)
      2'b01:   w_lane = {bus.address[1], 1'b0};
      2'b10:   w_lane = 2'b00;
      default: w_lane = bus.address[1:0];
    endcase
`endif
    case (w_size)
      2'b00:   w_be = 4'b0001 << w_lane;
      2'b01:   w_be = w_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
    case (w_size)
      2'b00:   w_wdata = {4{bus.writedata[7:0]}};
      2'b01:   w_wdata = {2{bus.writedata[15:0]}};
      default: w_wdata = bus.writedata;
    endcase
  end

  // Memory is deliberately not reset; writes commit at the accept edge.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && bus.req_write && !w_fault) begin
      for (int k = 0; k < 4; k++)
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word  <= '0;
      r_write <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'b00;
      r_lane  <= 2'b00;
    end else if (w_accept) begin
      r_word  <= r_mem[w_idx];
      r_write <= bus.req_write;
      r_uns   <= bus.req_unsigned;
      r_err   <= w_fault;
      r_size  <= w_size;
      r_lane  <= w_lane;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)               r_cnt <= 3'(WAIT_STATES);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - 3'd1;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (w_accept) w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: if (r_cnt <= 3'd1) w_next = S_RESP;
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Lane select and extension from the held word; outputs forced to 0 outside RESP.
  always_comb begin
    w_byte = r_word[8*r_lane +: 8];
    w_half = r_lane[1] ? r_word[31:16] : r_word[15:0];
    case (r_size)
      2'b00:   w_ext = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ext = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = r_word;
    endcase
    bus.readdata = '0;
    bus.rsp_err  = 1'b0;
    if (r_state == S_RESP) begin
      bus.rsp_err = r_err;
      if (!r_write && !r_err) bus.readdata = w_ext;
    end
  end
endmodule

// File: doc/dmem_subword_ctrl.md
# dmem_subword_ctrl

Parametrised, clocked MIPS data memory. It supersedes the single-cycle, word-only combinational data memory. Each access goes through a valid/ready request and a one-cycle response pulse, with a programmable number of wait states. Loads and stores can be byte, halfword or word, with sign- or zero-extended loads. The block sits between the MEM pipeline stage and the data store; the stage stalls while `req_ready` is low or a response is pending.

## Interface
- `DEPTH_WORDS`, 256 — number of 32-bit words. Power of two, ≥ 4.
- `WAIT_STATES`, 1 — extra cycles between accept and response. Range 0..7.
- `clk` in 1 — the single clock. All state changes on its rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — block can accept a request. High only in IDLE.
- `req_write` in 1 — 1 = store, 0 = load.
- `req_size` in 2 — 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1 — load extension: 1 = zero-extend (lbu/lhu), 0 = sign-extend. Ignored for stores and words.
- `address` in 32 — byte address.
- `writedata` in 32 — store data. Sub-word data is taken from the low bits.
- `rsp_valid` out 1 — one-cycle response pulse.
- `readdata` out 32 — extended load result. 0 for stores and errors.
- `rsp_err` out 1 — misaligned or reserved-size access. Valid with `rsp_valid`.

## Operation
- FSM states and transitions:
  - IDLE → WAIT on accept (`req_valid && req_ready`) when `WAIT_STATES > 0`.
  - IDLE → RESP on accept when `WAIT_STATES == 0`.
  - WAIT counts down `WAIT_STATES` cycles, then goes to RESP.
  - RESP always returns to IDLE.
- At accept, the block captures all request fields. Changes to inputs after accept are ignored.
- Only one access is outstanding at a time. There is no pipelining.
- Word index is `address[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
- Byte ordering is little-endian: byte lane k = bits `8k+7:8k`, with k = `address[1:0]`. Half lane = `address[1]`.
- Stores:
  - The memory array is written at the accept clock edge, using a byte-enable mask on the addressed lanes only.
  - Other lanes are preserved.
  - The response carries `readdata = 0`.
- Loads:
  - The word is read at the accept edge into a holding register.
  - Lane select and extension are applied to form `readdata`.
- Memory contents are not reset. Only control state and outputs are reset.

## Timing
- Reset values: `req_ready = 1`, `rsp_valid = 0`, `readdata = 0`, `rsp_err = 0`, FSM = IDLE, wait counter = 0.
- Latency: `rsp_valid` is high exactly `WAIT_STATES + 1` cycles after the accept edge, for one cycle.
- `readdata` and `rsp_err` are valid only while `rsp_valid` is high. They are held at 0 otherwise.
- `req_ready` falls in the cycle after accept and rises again in the cycle after RESP.
- Peak throughput is one access per `WAIT_STATES + 2` cycles.
- A request held with `req_valid` high while `req_ready` is low is not accepted until IDLE.
- Reset asserted mid-access:
  - The FSM returns to IDLE immediately and no response is produced.
  - A store already accepted stays committed.
- A load that follows a store to the same word observes the stored data.

## Configuration
- Macro: `DMEM_ALIGN_CHECK_EN`.
- Defined:
  - Faults are a half access with `address[0] = 1`, a word access with `address[1:0] != 0`, or `req_size = 11`.
  - A faulting access performs no write.
  - It returns `rsp_err = 1` and `readdata = 0`, with normal latency.
- Undefined:
  - Half accesses ignore `address[0]` and word accesses ignore `address[1:0]`, i.e. they are forced aligned.
  - `req_size = 11` is treated as word.
  - `rsp_err` is tied to 0.

## Test plan
- Word store/load: store `0xDEADBEEF` at `0x10`, then load word at `0x10` → `readdata = 0xDEADBEEF`, `rsp_err = 0`, with `rsp_valid` exactly `WAIT_STATES + 1` cycles after each accept.
- Byte lanes: store `0x11223344` at `0x20`, store byte `0xAA` at `0x22`, then load word at `0x20` → `0x11AA3344`. Load byte at `0x22` signed → `0xFFFFFFAA`; unsigned → `0x000000AA`.
- Halfword: store half `0x8001` at `0x32`, then load half at `0x32` signed → `0xFFFF8001`; unsigned → `0x00008001`. Word at `0x30` keeps its low half unchanged.
- Wrap-around with `DEPTH_WORDS = 256`: store `0x5A5A5A5A` at `0x400`, then load at `0x000` → `0x5A5A5A5A`.
- Misalignment with `DMEM_ALIGN_CHECK_EN`: store word at `0x41` → `rsp_err = 1`. A following load word at `0x40` returns the prior contents. Without the macro, the same store writes `0x40` and `rsp_err = 0`.
- Handshake and reset:
  - Hold `req_valid` high across a whole access; `req_ready` stays low through WAIT/RESP and only one access is accepted.
  - Assert `rst` during WAIT; no `rsp_valid` follows, and all outputs go to their reset values asynchronously.
